vx_launch_seq: RTL and testbench
================================

# vx_launch_seq

Synthesizable kernel-launch sequencer for Vortex FPGA bring-up and test harnesses. On a start pulse it writes a programmable list of DCR entries with a valid/ready handshake, holds the core in reset for a parametrised delay, releases it, waits for `vx_busy` to rise and then fall, and reports completion, run-cycle count and an optional watchdog timeout. It sits between a host or test controller and the Vortex top level, driving the core's DCR write port and `vx_reset`.

## Interface
- `NUM_DCRS`, 4: maximum DCR writes per launch.
- `DCR_ADDR_WIDTH`, 12: DCR address width.
- `DCR_DATA_WIDTH`, 32: DCR data width.
- `RESET_DELAY`, 8: cycles `vx_reset` is held after the DCR phase; must be ≥1.
- `CYCLE_WIDTH`, 44: run-cycle counter width.

Ports:
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `cfg_count`  in  $clog2(NUM_DCRS+1)  number of table entries to write; values >NUM_DCRS are clamped.
- `cfg_addr`  in  NUM_DCRS*DCR_ADDR_WIDTH  packed address table; entry i at [i*W +: W].
- `cfg_data`  in  NUM_DCRS*DCR_DATA_WIDTH  packed data table.
- `timeout_limit`  in  CYCLE_WIDTH  watchdog limit; 0 disables it.
- `dcr_wr_valid`  out  1  DCR write request.
- `dcr_wr_ready`  in  1  DCR write accept.
- `dcr_wr_addr`  out  DCR_ADDR_WIDTH  DCR address.
- `dcr_wr_data`  out  DCR_DATA_WIDTH  DCR data.
- `vx_reset`  out  1  active-high core reset.
- `vx_busy`  in  1  core busy status.
- `seq_busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `timed_out`  out  1  sticky; set when the last launch ended by watchdog.
- `run_cycles`  out  CYCLE_WIDTH  cycles spent in BUSY_WAIT and RUN for the last launch.

## Operation
- States:
  - IDLE → DCR on `start`, or → RESET on `start` when clamped `cfg_count`==0.
  - DCR → RESET after the last handshake.
  - RESET → BUSY_WAIT after RESET_DELAY cycles.
  - BUSY_WAIT → RUN when `vx_busy`=1.
  - RUN → DONE when `vx_busy`=0.
  - DONE → IDLE unconditionally.
- Start: latch the clamped count, clear `run_cycles` and `timed_out`, and set index to 0. The tables are sampled live during DCR; the host holds them stable until `seq_busy` falls.
- DCR: `dcr_wr_valid`=1, with addr/data from entry `index`. On valid&&ready, the index increments. Valid stays asserted back-to-back; the next entry is presented the cycle after the handshake. The last handshake moves to RESET. `dcr_wr_addr`/`dcr_wr_data` are 0 whenever valid=0.
- RESET: a delay counter runs 0..RESET_DELAY-1, then the block moves to BUSY_WAIT.
- `vx_reset`=1 in IDLE, DCR, RESET and DONE; 0 only in BUSY_WAIT and RUN.
- `run_cycles` increments each cycle in BUSY_WAIT/RUN and saturates at all-ones (no wrap).
- `start` is ignored outside IDLE. A `start` asserted in the DONE cycle is not seen; it is accepted on the following cycle in IDLE if still high.
- `vx_busy` is high on entry to BUSY_WAIT: the block goes to RUN next cycle.

## Timing
- Reset values: `dcr_wr_valid`=0, addr/data=0, `vx_reset`=1, `seq_busy`=0, `done`=0, `timed_out`=0, `run_cycles`=0, state IDLE.
- Asserting `resetn` mid-operation aborts immediately. `vx_reset` returns to 1, and `dcr_wr_valid` drops without completing the write.
- All outputs are registered; state is decoded from registers.
- `start` at cycle t: DCR valid at t+1. A zero-wait-state sink takes one cycle per entry.
- `vx_reset` deasserts exactly RESET_DELAY cycles after RESET entry.
- `done` is a 1-cycle pulse, high in the DONE cycle. `run_cycles` is final and stable from that cycle.

## Configuration
- `VX_LAUNCH_TIMEOUT_EN`:
  - Defined: in BUSY_WAIT/RUN, when `timeout_limit`≠0 and `run_cycles`==`timeout_limit`, the block goes to DONE with `timed_out`=1. `vx_reset` reasserts in the DONE cycle.
  - Undefined: no comparator. `timed_out` is tied 0 and `timeout_limit` is unused. A core that never raises or drops busy hangs the sequencer until `resetn`.

## Structure
- Shared package `vx_launch_pkg`: state enum `launch_state_e` (IDLE, DCR, RESET, BUSY_WAIT, RUN, DONE) and a default-delay constant.
- Sub-module `vx_launch_watchdog`: the saturating cycle counter and limit comparator. The comparator is compiled out under the macro; the counter always remains.

## Test plan
- `cfg_count`=2, entries {0x001→0x80000000, 0x002→0x0}, ready always 1 → two writes on consecutive cycles, then `vx_reset` high for 8 cycles, then low.
- Ready held 0 for 3 cycles on entry 0 → valid/addr/data stable across the stall; entry 1 follows the accept.
- `cfg_count`=0 → no DCR valid; RESET entered the cycle after `start`.
- Model raises busy 5 cycles after release and drops it 100 cycles later → `done` pulse, `run_cycles`=105, `timed_out`=0, `vx_reset`=1 in DONE.
- With `VX_LAUNCH_TIMEOUT_EN`, `timeout_limit`=50, and busy stuck high → `done` once `run_cycles`=50, `timed_out`=1; next `start` clears `timed_out`.
- `resetn` pulsed low during RUN → all outputs return to reset values asynchronously, within the same cycle.

Source files
------------

// File: rtl/vx_launch_pkg.sv
// Shared types and constants for the Vortex kernel-launch sequencer.
// Optional watchdog comparator is controlled by VX_LAUNCH_TIMEOUT_EN.
package vx_launch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DCR,
    RESET,
    BUSY_WAIT,
    RUN,
    DONE
  } launch_state_e;

  localparam int DEFAULT_RESET_DELAY = 8;

endpackage

// File: rtl/vx_launch_watchdog.sv
// Saturating run-cycle counter plus the optional limit comparator.
// The comparator only exists when VX_LAUNCH_TIMEOUT_EN is defined.
module vx_launch_watchdog
  import vx_launch_pkg::*;
#(
  parameter int CYCLE_WIDTH = 44
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   active,
  input  logic [CYCLE_WIDTH-1:0] timeout_limit,
  output logic [CYCLE_WIDTH-1:0] run_cycles,
  output logic                   expire
);

`ifdef VX_LAUNCH_TIMEOUT_EN
  assign expire = active && (timeout_limit != '0) && (run_cycles == timeout_limit);
`else
  logic limit_unused;
  assign limit_unused = ^timeout_limit;
  assign expire       = 1'b0;
`endif

  // The expiring cycle is not counted, so the reported count equals the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cycles <= '0;
    end else if (clear) begin
      run_cycles <= '0;
    end else if (active && !expire && (run_cycles != '1)) begin
      run_cycles <= run_cycles + CYCLE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/vx_launch_seq.sv
// Kernel-launch sequencer: DCR table writes, core reset hold, busy tracking.
// Define VX_LAUNCH_TIMEOUT_EN to enable the run-cycle watchdog.
module vx_launch_seq
  import vx_launch_pkg::*;
#(
  parameter int NUM_DCRS       = 4,
  parameter int DCR_ADDR_WIDTH = 12,
  parameter int DCR_DATA_WIDTH = 32,
  parameter int RESET_DELAY    = DEFAULT_RESET_DELAY,
  parameter int CYCLE_WIDTH    = 44
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [$clog2(NUM_DCRS+1)-1:0]      cfg_count,
  input  logic [NUM_DCRS*DCR_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [NUM_DCRS*DCR_DATA_WIDTH-1:0] cfg_data,
  input  logic [CYCLE_WIDTH-1:0]             timeout_limit,
  output logic                               dcr_wr_valid,
  input  logic                               dcr_wr_ready,
  output logic [DCR_ADDR_WIDTH-1:0]          dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0]          dcr_wr_data,
  output logic                               vx_reset,
  input  logic                               vx_busy,
  output logic                               seq_busy,
  output logic                               done,
  output logic                               timed_out,
  output logic [CYCLE_WIDTH-1:0]             run_cycles,
  output launch_state_e                      dbg_state
);

  localparam int CNT_W = $clog2(NUM_DCRS + 1);
  localparam int DLY_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam int AW    = DCR_ADDR_WIDTH;
  localparam int DW    = DCR_DATA_WIDTH;

  launch_state_e       state_q;
  launch_state_e       state_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    index_q;
  logic [CNT_W-1:0]    nxt_idx;
  logic [CNT_W-1:0]    clamped;
  logic [DLY_W-1:0]    dly_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       data_q;
  logic                start_fire;
  logic                hs;
  logic                last;
  logic                dly_end;
  logic                active;
  logic                expire;

  assign clamped    = (cfg_count > CNT_W'(NUM_DCRS)) ? CNT_W'(NUM_DCRS) : cfg_count;
  assign start_fire = (state_q == IDLE) && start;
  // Valid is high for the whole DCR state; a write completes on any cycle
  // where valid && ready, and the next entry appears the following cycle.
  assign hs         = (state_q == DCR) && dcr_wr_ready;
  assign last       = (index_q == (count_q - CNT_W'(1)));
  assign nxt_idx    = index_q + CNT_W'(1);
  assign dly_end    = (dly_q == DLY_W'(RESET_DELAY - 1));
  assign active     = (state_q == BUSY_WAIT) || (state_q == RUN);

  vx_launch_watchdog #(
    .CYCLE_WIDTH(CYCLE_WIDTH)
  ) u_watchdog (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (start_fire),
    .active       (active),
    .timeout_limit(timeout_limit),
    .run_cycles   (run_cycles),
    .expire       (expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (clamped == '0) ? RESET : DCR;
      end
      DCR: begin
        if (hs && last) state_d = RESET;
      end
      RESET: begin
        if (dly_end) state_d = BUSY_WAIT;
      end
      BUSY_WAIT: begin
        if (expire)       state_d = DONE;
        else if (vx_busy) state_d = RUN;
      end
      RUN: begin
        if (expire || !vx_busy) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dcr_wr_valid = (state_q == DCR);
    vx_reset     = !active;
    seq_busy     = (state_q != IDLE);
    done         = (state_q == DONE);
    dbg_state    = state_q;
  end

  assign dcr_wr_addr = addr_q;
  assign dcr_wr_data = data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      index_q <= '0;
      dly_q   <= '0;
    end else begin
      if (start_fire) begin
        count_q <= clamped;
        index_q <= '0;
      end else if (hs) begin
        index_q <= nxt_idx;
      end
      if ((state_q == RESET) && !dly_end) dly_q <= dly_q + DLY_W'(1);
      else                                dly_q <= '0;
    end
  end

  // Address/data registers hold the presented entry and read 0 whenever valid is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (start_fire) begin
      if (clamped != '0) begin
        addr_q <= cfg_addr[0 +: AW];
        data_q <= cfg_data[0 +: DW];
      end else begin
        addr_q <= '0;
        data_q <= '0;
      end
    end else if (hs) begin
      if (last) begin
        addr_q <= '0;
        data_q <= '0;
      end else begin
        addr_q <= cfg_addr[nxt_idx*AW +: AW];
        data_q <= cfg_data[nxt_idx*DW +: DW];
      end
    end
  end

`ifdef VX_LAUNCH_TIMEOUT_EN
  logic timed_out_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timed_out_q <= 1'b0;
    end else if (start_fire) begin
      timed_out_q <= 1'b0;
    end else if (expire) begin
      timed_out_q <= 1'b1;
    end
  end
  assign timed_out = timed_out_q;
`else
  assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_vx_launch_seq.sv
// Self-checking bench for vx_launch_seq: directed launches with an expected
// queue for DCR writes and completion reports, checked by a negedge monitor.
module tb_vx_launch_seq;
  import vx_launch_pkg::*;

  localparam int NUM_DCRS = 4;
  localparam int AW       = 12;
  localparam int DW       = 32;
  localparam int RD       = 8;
  localparam int CW       = 44;
  localparam int CNT_W    = $clog2(NUM_DCRS + 1);

  logic                   clk;
  logic                   resetn;
  logic                   start;
  logic [CNT_W-1:0]       cfg_count;
  logic [NUM_DCRS*AW-1:0] cfg_addr;
  logic [NUM_DCRS*DW-1:0] cfg_data;
  logic [CW-1:0]          timeout_limit;
  logic                   dcr_wr_valid;
  logic                   dcr_wr_ready;
  logic [AW-1:0]          dcr_wr_addr;
  logic [DW-1:0]          dcr_wr_data;
  logic                   vx_reset;
  logic                   vx_busy;
  logic                   seq_busy;
  logic                   done;
  logic                   timed_out;
  logic [CW-1:0]          run_cycles;
  launch_state_e          dbg_state;

  logic [AW+DW-1:0] exp_q[$];
  logic [CW:0]      exp_done_q[$];
  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;

  vx_launch_seq #(
    .NUM_DCRS(NUM_DCRS), .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW),
    .RESET_DELAY(RD), .CYCLE_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .cfg_count(cfg_count),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .timeout_limit(timeout_limit),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_ready(dcr_wr_ready),
    .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .vx_reset(vx_reset), .vx_busy(vx_busy), .seq_busy(seq_busy), .done(done),
    .timed_out(timed_out), .run_cycles(run_cycles), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (dcr_wr_valid && dcr_wr_ready) begin
        if (exp_q.size() == 0) chk("dcr_unexpected", 64'({dcr_wr_addr, dcr_wr_data}), 64'd0 - 64'd1);
        else chk("dcr_write", 64'({dcr_wr_addr, dcr_wr_data}), 64'(exp_q.pop_front()));
      end
      if (!dcr_wr_valid) chk("bus_zero_when_idle", 64'({dcr_wr_addr, dcr_wr_data}), 64'd0);
      if (done) begin
        done_seen++;
        chk("vx_reset_in_done", 64'(vx_reset), 64'd1);
        if (exp_done_q.size() == 0) chk("done_unexpected", 64'({timed_out, run_cycles}), 64'd0 - 64'd1);
        else chk("done_report", 64'({timed_out, run_cycles}), 64'(exp_done_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_entry(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_addr[i*AW +: AW] = a;
    cfg_data[i*DW +: DW] = d;
    exp_q.push_back({a, d});
  endtask

  task automatic wait_release();
    int n = 0;
    while (vx_reset && n < 1000) begin
      step();
      n++;
    end
    chk("release_wait", 64'(vx_reset), 64'd0);
  endtask

  task automatic run_core(input int rise, input int hold);
    wait_release();
    repeat (rise - 1) step();
    vx_busy = 1'b1;
    repeat (hold) step();
    vx_busy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (seq_busy && n < 1000) begin
      step();
      n++;
    end
    chk(name, 64'(seq_busy), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(dcr_wr_valid), 64'd0);
    chk({tag, "_bus"}, 64'({dcr_wr_addr, dcr_wr_data}), 64'd0);
    chk({tag, "_vx_reset"}, 64'(vx_reset), 64'd1);
    chk({tag, "_seq_busy"}, 64'(seq_busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_timed_out"}, 64'(timed_out), 64'd0);
    chk({tag, "_run_cycles"}, 64'(run_cycles), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    int n;
    resetn = 1'b0; start = 1'b0; cfg_count = '0; cfg_addr = '0; cfg_data = '0;
    timeout_limit = '0; dcr_wr_ready = 1'b0; vx_busy = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    resetn = 1'b1;
    step();

    // two entries, zero-wait sink, then a 5/100 busy profile
    cfg_count = 3'd2;
    set_entry(0, 12'h001, 32'h8000_0000);
    set_entry(1, 12'h002, 32'h0000_0000);
    dcr_wr_ready = 1'b1;
    timeout_limit = 44'd200;
    exp_done_q.push_back({1'b0, 44'd105});
    pulse_start();
    chk("t1_entry0", 64'({dcr_wr_valid, dcr_wr_addr, dcr_wr_data}), 64'({1'b1, 12'h001, 32'h8000_0000}));
    step();
    chk("t1_entry1", 64'({dcr_wr_valid, dcr_wr_addr, dcr_wr_data}), 64'({1'b1, 12'h002, 32'h0}));
    step();
    chk("t1_reset_state", 64'(dbg_state), 64'(RESET));
    chk("t1_writes_drained", 64'(exp_q.size()), 64'd0);
    n = 0;
    while (vx_reset && n < 50) begin
      step();
      n++;
    end
    chk("t1_reset_len", 64'(n), 64'(RD));
    run_core(5, 100);
    wait_idle("t1_idle");
    chk("t1_done_count", 64'(done_seen), 64'd1);
    chk("t1_run_cycles_hold", 64'(run_cycles), 64'd105);

    // three-cycle stall on entry 0
    dcr_wr_ready = 1'b0;
    timeout_limit = '0;
    cfg_count = 3'd2;
    set_entry(0, 12'h123, 32'hDEAD_BEEF);
    set_entry(1, 12'hABC, 32'h1234_5678);
    exp_done_q.push_back({1'b0, 44'd4});
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      chk("t2_stall_hold", 64'({dcr_wr_valid, dcr_wr_addr, dcr_wr_data}), 64'({1'b1, 12'h123, 32'hDEAD_BEEF}));
      if (k == 2) dcr_wr_ready = 1'b1;
      step();
    end
    chk("t2_entry1", 64'({dcr_wr_valid, dcr_wr_addr, dcr_wr_data}), 64'({1'b1, 12'hABC, 32'h1234_5678}));
    run_core(1, 3);
    wait_idle("t2_idle");
    chk("t2_done_count", 64'(done_seen), 64'd2);

    // empty table, busy already high at release
    cfg_count = 3'd0;
    vx_busy = 1'b1;
    exp_done_q.push_back({1'b0, 44'd10});
    pulse_start();
    chk("t3_direct_reset", 64'({dcr_wr_valid, dbg_state}), 64'({1'b0, RESET}));
    wait_release();
    chk("t3_busy_wait", 64'(dbg_state), 64'(BUSY_WAIT));
    step();
    chk("t3_run_next", 64'(dbg_state), 64'(RUN));
    repeat (8) step();
    vx_busy = 1'b0;
    wait_idle("t3_idle");
    chk("t3_done_count", 64'(done_seen), 64'd3);

    // count of 7 clamps to the four-entry table
    cfg_count = 3'd7;
    set_entry(0, 12'h100, 32'h0000_0001);
    set_entry(1, 12'h200, 32'h0000_0002);
    set_entry(2, 12'h300, 32'h0000_0003);
    set_entry(3, 12'h400, 32'h0000_0004);
    exp_done_q.push_back({1'b0, 44'd8});
    pulse_start();
    run_core(2, 6);
    wait_idle("t4_idle");
    chk("t4_writes_drained", 64'(exp_q.size()), 64'd0);
    chk("t4_done_count", 64'(done_seen), 64'd4);

`ifdef VX_LAUNCH_TIMEOUT_EN
    // busy stuck high hits the watchdog; next start clears timed_out
    cfg_count = 3'd1;
    set_entry(0, 12'h010, 32'h0000_0055);
    timeout_limit = 44'd50;
    exp_done_q.push_back({1'b1, 44'd50});
    pulse_start();
    wait_release();
    vx_busy = 1'b1;
    wait_idle("t5_idle");
    chk("t5_timed_out_sticky", 64'(timed_out), 64'd1);
    vx_busy = 1'b0;
    timeout_limit = '0;
    cfg_count = 3'd0;
    exp_done_q.push_back({1'b0, 44'd5});
    pulse_start();
    chk("t5_timed_out_cleared", 64'(timed_out), 64'd0);
    run_core(3, 2);
    wait_idle("t5b_idle");
`endif

    // asynchronous reset while RUN
    cfg_count = 3'd1;
    set_entry(0, 12'h7FF, 32'hCAFE_F00D);
    pulse_start();
    wait_release();
    vx_busy = 1'b1;
    step();
    step();
    chk("t6_in_run", 64'(dbg_state), 64'(RUN));
    #3;
    resetn = 1'b0;
    #1;
    chk_reset("t6_async");
    vx_busy = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();

    chk("final_dcr_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
